// File: rtl/gpio_in_conditioner.sv
// Per-pin GPIO input conditioning: synchronizer, debounce, edge detection and
// sticky pending flags with an OR-reduced interrupt line.
module gpio_in_conditioner #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [CNT_W-1:0] db_limit,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] pin_clean,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] irq_pend,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_w;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] clean_dly_q;
  logic [WIDTH-1:0] rise_q, fall_q;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             irq_q;

  // Plain flop chain: no logic between stages so metastability can settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // A level commits only once it has differed from the clean value for more
  // than db_limit cycles; using >= lets a lowered limit take effect at once.
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_w[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= db_limit) begin
        clean_d[i] = sync_w[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clean_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      clean_q <= clean_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Set wins over a simultaneous clear so an edge is never lost.
  always_comb begin
    pend_d = (rise_q & rise_en) | (fall_q & fall_en) | (pend_q & ~irq_clr);
  end

  // Edges are taken against a delayed copy, so pulses trail pin_clean by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      clean_dly_q <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      pend_q      <= '0;
      irq_q       <= 1'b0;
    end else begin
      clean_dly_q <= clean_q;
      rise_q      <= clean_q & ~clean_dly_q;
      fall_q      <= ~clean_q & clean_dly_q;
      pend_q      <= pend_d;
      irq_q       <= |pend_q;
    end
  end

  assign pin_clean  = clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign irq_pend   = pend_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner: transparent-mode vector table plus
// hand-written debounce, glitch, interrupt and reset sequences.
module tb_gpio_in_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pin_in;
  logic [15:0] db_limit;
  logic [7:0]  rise_en, fall_en, irq_clr;
  logic [7:0]  pin_clean, rise_pulse, fall_pulse, irq_pend;
  logic        irq;

  int errors = 0;
  int checks = 0;

  gpio_in_conditioner #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .pin_in    (pin_in),
    .db_limit  (db_limit),
    .rise_en   (rise_en),
    .fall_en   (fall_en),
    .irq_clr   (irq_clr),
    .pin_clean (pin_clean),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .irq_pend  (irq_pend),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pin;
    logic [7:0] exp_rise;
    logic [7:0] exp_fall;
    logic [7:0] exp_pend;
    logic       exp_irq;
  } vec_t;

  vec_t tbl [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    logic bad;
    logic found;

    // rise_en=0F, fall_en=F0 throughout the table.
    tbl[0] = '{pin: 8'hA5, exp_rise: 8'hA5, exp_fall: 8'h00, exp_pend: 8'h05, exp_irq: 1'b1};
    tbl[1] = '{pin: 8'h5A, exp_rise: 8'h5A, exp_fall: 8'hA5, exp_pend: 8'hAA, exp_irq: 1'b1};
    tbl[2] = '{pin: 8'h5B, exp_rise: 8'h01, exp_fall: 8'h00, exp_pend: 8'h01, exp_irq: 1'b1};
    tbl[3] = '{pin: 8'hFF, exp_rise: 8'hA4, exp_fall: 8'h00, exp_pend: 8'h04, exp_irq: 1'b1};
    tbl[4] = '{pin: 8'h00, exp_rise: 8'h00, exp_fall: 8'hFF, exp_pend: 8'hF0, exp_irq: 1'b1};

    rst = 1'b1; pin_in = 8'h00; db_limit = 16'd0;
    rise_en = 8'h00; fall_en = 8'h00; irq_clr = 8'h00;
    repeat (3) tick();
    check("reset_clean", pin_clean, 8'h00);
    check("reset_rise", rise_pulse, 8'h00);
    check("reset_fall", fall_pulse, 8'h00);
    check("reset_pend", irq_pend, 8'h00);
    check("reset_irq", irq, 1'b0);
    rst = 1'b0;

    // Transparent debounce: clean after 3 edges, pulse on 4th, pending on 5th.
    rise_en = 8'h0F; fall_en = 8'hF0;
    for (int k = 0; k < 5; k++) begin
      pin_in = tbl[k].pin;
      repeat (3) tick();
      check($sformatf("tbl%0d_clean", k), pin_clean, tbl[k].pin);
      tick();
      check($sformatf("tbl%0d_rise", k), rise_pulse, tbl[k].exp_rise);
      check($sformatf("tbl%0d_fall", k), fall_pulse, tbl[k].exp_fall);
      tick();
      check($sformatf("tbl%0d_pend", k), irq_pend, tbl[k].exp_pend);
      irq_clr = 8'hFF;
      tick();
      check($sformatf("tbl%0d_irq", k), irq, tbl[k].exp_irq);
      irq_clr = 8'h00;
      repeat (2) tick();
    end
    check("tbl_irq_idle", irq, 1'b0);

    // db_limit=3: pin 0 rise needs 6 edges, pulse on the 7th.
    db_limit = 16'd3; rise_en = 8'h01; fall_en = 8'h00;
    pin_in = 8'h01;
    n = 0;
    while (!pin_clean[0] && n < 20) begin
      tick();
      n++;
    end
    check("deb_latency", n, 6);
    check("deb_no_early_pulse", rise_pulse, 8'h00);
    tick();
    check("deb_rise_pulse", rise_pulse, 8'h01);
    tick();
    check("deb_rise_width", rise_pulse, 8'h00);
    check("deb_pend", irq_pend, 8'h01);
    check("deb_irq_lag", irq, 1'b0);
    rise_en = 8'h00;
    tick();
    check("deb_irq", irq, 1'b1);
    check("deb_pend_kept_disabled", irq_pend, 8'h01);
    irq_clr = 8'h01;
    tick();
    irq_clr = 8'h00;
    check("deb_pend_cleared", irq_pend, 8'h00);
    check("deb_irq_still", irq, 1'b1);
    tick();
    check("deb_irq_cleared", irq, 1'b0);

    // Glitch of 3 cycles on pin 1 must not commit with db_limit=3.
    rise_en = 8'h03;
    pin_in = 8'h03;
    repeat (3) tick();
    pin_in = 8'h01;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (pin_clean[1] || rise_pulse[1] || irq_pend[1]) bad = 1'b1;
    end
    check("glitch_rejected", bad, 1'b0);
    check("glitch_pin0_kept", pin_clean, 8'h01);

    // Clear strobe coinciding with a fall pulse loses to the set.
    db_limit = 16'd0; fall_en = 8'h04;
    pin_in = 8'h05;
    repeat (6) tick();
    check("pin2_high", pin_clean, 8'h05);
    pin_in = 8'h01;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (fall_pulse[2]) found = 1'b1;
    end
    check("pin2_fall_seen", found, 1'b1);
    irq_clr = 8'h04;
    tick();
    check("set_beats_clear", irq_pend[2], 1'b1);
    tick();
    irq_clr = 8'h00;
    check("clear_alone", irq_pend[2], 1'b0);

    // Reset mid-debounce on pin 4 (cnt=2), then full latency again.
    db_limit = 16'd3;
    pin_in = 8'h11;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_outputs", {pin_clean, rise_pulse, fall_pulse, irq_pend, 7'd0, irq}, 40'd0);
    rst = 1'b0;
    n = 0;
    bad = 1'b0;
    while (!pin_clean[4] && n < 20) begin
      tick();
      n++;
      if (fall_pulse != 8'h00 || irq_pend != 8'h00) bad = 1'b1;
    end
    check("rst_relatency", n, 6);
    check("rst_no_spurious", bad, 1'b0);
    check("rst_commit_both", pin_clean, 8'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
